// File: rtl/count_compare_pkg.sv
// Shared types for the compare/PWM stage: FSM state encoding and the
// period/duty configuration record used by the active and shadow registers.
package count_compare_pkg;

    localparam int CC_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_UNCONF = 2'd0,
        ST_RUN    = 2'd1,
        ST_PEND   = 2'd2
    } cc_state_t;

    typedef struct packed {
        logic [CC_WIDTH-1:0] period;
        logic [CC_WIDTH-1:0] duty;
    } cc_cfg_t;

endpackage

// File: rtl/cc_cfg_buffer.sv
// Double-buffered period/duty configuration: the first config goes live at
// once, later ones wait in the shadow registers until the counter wraps.
module cc_cfg_buffer
    import count_compare_pkg::*;
(
    input  logic      clk,
    input  logic      nreset,
    input  logic      wrp_i,
    input  logic      cfg_valid_i,
    input  cc_cfg_t   cfg_i,
    output logic      cfg_ready_o,
    output cc_cfg_t   cfg_eff_o,
    output logic      running_o,
    output cc_state_t state_o
);

    cc_state_t state_q, state_d;
    cc_cfg_t   active_q, active_d;
    cc_cfg_t   shadow_q, shadow_d;
    logic      accept;

    // Handshake: a config transfers on any rising edge where cfg_valid_i and
    // cfg_ready_o are both high; cfg_ready_o is low only while a config waits.
    assign cfg_ready_o = (state_q != ST_PEND);
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign running_o   = (state_q != ST_UNCONF);
    assign state_o     = state_q;

    // On the wrap that promotes the shadow, that same cycle already compares against it.
    assign cfg_eff_o = (state_q == ST_PEND && wrp_i) ? shadow_q : active_q;

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_UNCONF: begin
                if (accept) begin
                    active_d = cfg_i;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    shadow_d = cfg_i;
                    state_d  = ST_PEND;
                end
            end
            ST_PEND: begin
                if (wrp_i) begin
                    active_d = shadow_q;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_UNCONF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= ST_UNCONF;
            active_q <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/count_compare.sv
// Compare/PWM stage downstream of the free-running counter: turns each count
// sample into registered PWM, match, wrap and overrun indications.
module count_compare
    import count_compare_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] count,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    input  logic             clr_flags,
    output logic             pwm_out,
    output logic             duty_match,
    output logic             period_match,
    output logic             wrap,
    output logic             overrun,
    output logic             running
);

    logic [WIDTH-1:0] prev_count_q;
    logic             chg, wrp, cfg_live;
    cc_cfg_t          cfg_in, cfg_eff;
    cc_state_t        cfg_state;

    logic pwm_q, pwm_d;
    logic duty_match_q, duty_match_d;
    logic period_match_q, period_match_d;
    logic wrap_q, wrap_d;
    logic overrun_q, overrun_d;

    assign chg    = (count != prev_count_q);
    assign wrp    = (count <  prev_count_q);
    assign cfg_in = '{period: cfg_period, duty: cfg_duty};

    cc_cfg_buffer u_cfg_buffer (
        .clk         (clk),
        .nreset      (nreset),
        .wrp_i       (wrp),
        .cfg_valid_i (cfg_valid),
        .cfg_i       (cfg_in),
        .cfg_ready_o (cfg_ready),
        .cfg_eff_o   (cfg_eff),
        .running_o   (running),
        .state_o     (cfg_state)
    );

    assign cfg_live = (cfg_state != ST_UNCONF);

    always_comb begin
        pwm_d          = cfg_live && (count < cfg_eff.duty);
        duty_match_d   = cfg_live && chg && (count == cfg_eff.duty);
        period_match_d = cfg_live && chg && (count == cfg_eff.period);
        wrap_d         = cfg_live && wrp;
        // A fresh overrun beats a simultaneous clear.
        if (cfg_live && (count > cfg_eff.period)) begin
            overrun_d = 1'b1;
        end else if (clr_flags) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            prev_count_q   <= '0;
            pwm_q          <= 1'b0;
            duty_match_q   <= 1'b0;
            period_match_q <= 1'b0;
            wrap_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            prev_count_q   <= count;
            pwm_q          <= pwm_d;
            duty_match_q   <= duty_match_d;
            period_match_q <= period_match_d;
            wrap_q         <= wrap_d;
            overrun_q      <= overrun_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign duty_match   = duty_match_q;
    assign period_match = period_match_q;
    assign wrap         = wrap_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_count_compare.sv
// Directed bench for count_compare; expected output vectors are written by
// hand as {pwm, duty_match, period_match, wrap, overrun, running, cfg_ready}.
module tb_count_compare;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [15:0] count = '0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_period = '0;
    logic [15:0] cfg_duty = '0;
    logic        clr_flags = 1'b0;
    logic        cfg_ready, pwm_out, duty_match, period_match, wrap, overrun, running;

    count_compare #(.WIDTH(16)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .count        (count),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .clr_flags    (clr_flags),
        .pwm_out      (pwm_out),
        .duty_match   (duty_match),
        .period_match (period_match),
        .wrap         (wrap),
        .overrun      (overrun),
        .running      (running)
    );

    // clock
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [6:0]  exp_q[$];
    string       name_q[$];
    logic [6:0]  act;

    assign act = {pwm_out, duty_match, period_match, wrap, overrun, running, cfg_ready};

    // driver: one cycle of inputs, expectation is the output after the next edge
    task automatic drive(input string nm, input logic rn, input logic [15:0] c,
                         input logic v, input logic [15:0] p, input logic [15:0] d,
                         input logic clr, input logic [6:0] e);
        @(negedge clk);
        nreset     = rn;
        count      = c;
        cfg_valid  = v;
        cfg_period = p;
        cfg_duty   = d;
        clr_flags  = clr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tk(input string nm, input logic [15:0] c, input logic [6:0] e);
        drive(nm, 1'b1, c, 1'b0, 16'd0, 16'd0, 1'b0, e);
    endtask

    task automatic tcfg(input string nm, input logic [15:0] c, input logic [15:0] p,
                        input logic [15:0] d, input logic [6:0] e);
        drive(nm, 1'b1, c, 1'b1, p, d, 1'b0, e);
    endtask

    task automatic tclr(input string nm, input logic [15:0] c, input logic [6:0] e);
        drive(nm, 1'b1, c, 1'b0, 16'd0, 16'd0, 1'b1, e);
    endtask

    task automatic trst(input string nm, input logic [15:0] c, input logic [6:0] e);
        drive(nm, 1'b0, c, 1'b0, 16'd0, 16'd0, 1'b0, e);
    endtask

    // scoreboard monitor
    initial begin
        logic [6:0] e;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s: got %b expected %b (pwm,dm,pm,wrap,ovr,run,rdy) count=%0d",
                             nm, act, e, count);
                end
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: stimulus did not complete in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        // reset and unconfigured counting
        for (int i = 0; i < 5; i++) trst("reset", 16'd0, 7'b0000001);
        for (int c = 0; c <= 20; c++) tk("unconf", 16'(c), 7'b0000001);

        // basic PWM, period 9 duty 3
        tcfg("cfg_unconf", 16'd0, 16'd9, 16'd3, 7'b0000011);
        tk("stall_first", 16'd0, 7'b1000011);
        tk("pwm_c1", 16'd1, 7'b1000011);
        tk("pwm_c2", 16'd2, 7'b1000011);
        tk("duty_c3", 16'd3, 7'b0100011);
        for (int c = 4; c <= 8; c++) tk("low_c4_8", 16'(c), 7'b0000011);
        tk("period_c9", 16'd9, 7'b0010011);
        tk("wrap_c0", 16'd0, 7'b1001011);
        tk("pwm_c1b", 16'd1, 7'b1000011);
        tk("pwm_c2b", 16'd2, 7'b1000011);
        tk("duty_c3b", 16'd3, 7'b0100011);
        tk("stall_c3", 16'd3, 7'b0000011);
        for (int c = 4; c <= 8; c++) tk("low_c4_8b", 16'(c), 7'b0000011);
        tk("period_c9b", 16'd9, 7'b0010011);
        tk("wrap_c0b", 16'd0, 7'b1001011);
        tk("pwm_c1c", 16'd1, 7'b1000011);
        tk("pwm_c2c", 16'd2, 7'b1000011);

        // double-buffered update to duty 6 mid-period
        tcfg("db_accept", 16'd3, 16'd9, 16'd6, 7'b0100010);
        for (int c = 4; c <= 8; c++) tk("db_old_duty", 16'(c), 7'b0000010);
        tk("db_period", 16'd9, 7'b0010010);
        tk("db_wrap_apply", 16'd0, 7'b1001011);
        for (int c = 1; c <= 5; c++) tk("db_new_high", 16'(c), 7'b1000011);
        tk("db_duty6", 16'd6, 7'b0100011);
        tk("db_c7", 16'd7, 7'b0000011);
        tk("db_c8", 16'd8, 7'b0000011);
        tk("db_c9", 16'd9, 7'b0010011);

        // accept on the wrap cycle: duty 2 waits a full period
        tcfg("wa_accept", 16'd0, 16'd9, 16'd2, 7'b1001010);
        for (int c = 1; c <= 5; c++) tk("wa_old_high", 16'(c), 7'b1000010);
        tk("wa_old_duty6", 16'd6, 7'b0100010);
        tk("wa_c7", 16'd7, 7'b0000010);
        tk("wa_c8", 16'd8, 7'b0000010);
        tk("wa_c9", 16'd9, 7'b0010010);
        tk("wa_apply", 16'd0, 7'b1001011);
        tk("wa_c1", 16'd1, 7'b1000011);
        tk("wa_duty2", 16'd2, 7'b0100011);
        for (int c = 3; c <= 8; c++) tk("wa_low", 16'(c), 7'b0000011);
        tk("wa_c9b", 16'd9, 7'b0010011);

        // overrun with period 9
        tk("ovr_set_c10", 16'd10, 7'b0000111);
        tclr("ovr_clr_lose", 16'd11, 7'b0000111);
        tk("ovr_c12", 16'd12, 7'b0000111);
        tk("ovr_wrap", 16'd0, 7'b1001111);
        tclr("ovr_clr_win", 16'd1, 7'b1000011);

        // full-range wrap with period 0xFFFF, duty 0x8000
        tcfg("fr_accept", 16'd2, 16'hFFFF, 16'h8000, 7'b0100010);
        tk("fr_apply", 16'd0, 7'b1001011);
        tk("fr_7fff", 16'h7FFF, 7'b1000011);
        tk("fr_duty", 16'h8000, 7'b0100011);
        tk("fr_fffe", 16'hFFFE, 7'b0000011);
        tk("fr_period", 16'hFFFF, 7'b0010011);
        tk("fr_wrap", 16'h0000, 7'b1001011);

        // reset while a config is pending
        tcfg("rp_accept", 16'd1, 16'd5, 16'd1, 7'b1000010);
        trst("rp_reset", 16'd0, 7'b0000001);
        tk("rp_idle", 16'd0, 7'b0000001);
        tk("rp_c5", 16'd5, 7'b0000001);
        tk("rp_wrap_noapply", 16'd0, 7'b0000001);
        tk("rp_c1", 16'd1, 7'b0000001);

        @(posedge clk);
        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_compare.md
# count_compare

Compare/PWM stage that consumes the 16-bit count produced by the free-running counter stage (`simple_counter`) and turns it into timing events. It holds a double-buffered period/duty configuration, applies new settings only at a counter wrap, and produces a registered PWM level plus single-cycle match, period and wrap pulses. It also keeps a sticky overrun flag. It sits directly downstream of the counter, sharing its clock and reset.

## Interface
Parameters:
- `WIDTH`, 16: count and config width; must match the counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `nreset`  in  1  reset, synchronous, active-low.
- `count`  in  WIDTH  counter value, sampled every cycle.
- `cfg_valid`  in  1  a new period/duty pair is offered.
- `cfg_ready`  out  1  the block can accept a config this cycle.
- `cfg_period`  in  WIDTH  new period (terminal count).
- `cfg_duty`  in  WIDTH  new duty threshold.
- `clr_flags`  in  1  clears `overrun`.
- `pwm_out`  out  1  registered PWM level.
- `duty_match`  out  1  one-cycle pulse when the count reaches the duty value.
- `period_match`  out  1  one-cycle pulse when the count reaches the period value.
- `wrap`  out  1  one-cycle pulse when the count decreases.
- `overrun`  out  1  sticky flag: the count went above the active period.
- `running`  out  1  an active configuration exists.

## Operation
- Internal registers: `prev_count`, `active_period`, `active_duty`, `shadow_period`, `shadow_duty`, and a 2-bit `state`.
- Per-cycle events, all computed on cycle t:
  - `chg` = (`count` != `prev_count`).
  - `wrp` = (`count` < `prev_count`), unsigned compare. This covers 0xFFFF→0 and any counter reset to 0.
- FSM:
  - UNCONF: `cfg_ready`=1. On accept (`cfg_valid`&&`cfg_ready`), load the config directly into the active registers and go to RUN.
  - RUN: `cfg_ready`=1. On accept, load the shadow registers and go to PEND. A `wrp` in the accept cycle does NOT apply that config; it applies at the next wrap.
  - PEND: `cfg_ready`=0. On `wrp`, copy shadow into active and go to RUN.
- Effective values for cycle t: use the shadow values if state is PEND and `wrp` is true, otherwise the active values. All comparisons use the effective values.
- Outputs (registered, valid at t+1; all are 0 while in UNCONF):
  - `pwm_out` = `count` < duty_eff. So duty=0 gives always low; duty>period gives high for the whole period.
  - `duty_match` = `chg` && `count`==duty_eff.
  - `period_match` = `chg` && `count`==period_eff.
  - `wrap` = `wrp`.
  - `overrun` is set when `count` > period_eff. It is cleared by `clr_flags` unless set in the same cycle; set wins.
- `running` = state != UNCONF.
- `prev_count` updates every cycle, including in UNCONF.
- Config is never lost: `cfg_ready` low holds the requester.

## Timing
- Latency: one cycle from a `count` sample to the matching output.
- Handshake: a transfer happens on any rising edge where `cfg_valid`&&`cfg_ready`. `cfg_valid` may stay high across a stall.
- Reset, applied at the edge while `nreset`=0:
  - `state`=UNCONF; all active, shadow and `prev_count` registers are 0.
  - `pwm_out`=`duty_match`=`period_match`=`wrap`=`overrun`=`running`=0.
  - `cfg_ready`=1 from the first cycle after reset.
- Reset mid-PEND discards the shadow config.
- First sample after reset: `count`=0 equals `prev_count`=0, so there is no `chg` and no `wrp`.
- A stalled counter (no `chg`) produces no repeated match pulses; `pwm_out` holds its level.

## Structure
- Package `count_compare_pkg` holds:
  - the `cc_state_t` enum (UNCONF, RUN, PEND);
  - a `cc_cfg_t` struct {period, duty}, used for the active and shadow registers.
- One sub-module, `cc_cfg_buffer`, holds the FSM, the shadow/active registers and `cfg_ready`. It exports `period_eff`, `duty_eff` and `running`.
- The top level holds `prev_count`, the comparators and the output registers.

## Test plan
- **Reset and unconfigured counting.** Hold `nreset`=0 for 5 cycles, then count 0..20 with no config → all outputs 0, `cfg_ready`=1.
- **Basic PWM.** Config period=9, duty=3, with a counter that wraps 9→0 via reset → `pwm_out` is high for counts 0–2 (one cycle late). `duty_match` pulses at count 3 and `period_match` at count 9, each once per period. `wrap` pulses at the 9→0 step.
- **Double-buffered update.** While running duty=3, offer duty=6 mid-period → `cfg_ready` drops for one or more cycles. The old duty persists until the wrap. At the wrap cycle's output, count 0 is compared against 6, and the match then pulses at count 6.
- **Accept on the wrap cycle.** Assert `cfg_valid` on the exact cycle of a wrap → the new config takes effect only at the following wrap.
- **Overrun.** Period=9 with a counter running freely to 12 → `overrun` sets at the output for count 10. `clr_flags` at count 11 leaves it set (count 11 > 9 re-sets it). `clr_flags` after the wrap clears it to 0.
- **Full-range wrap and reset mid-PEND.** A 16-bit counter wrapping 0xFFFF→0 with period=0xFFFF → `period_match` fires, then `wrap`. Asserting `nreset`=0 while in PEND → `running`=0 and `cfg_ready`=1; the shadow config is never applied.
